// File: rtl/rv_target_sink.sv
// Ready/valid sink with programmable backpressure, transfer statistics and an
// upstream protocol checker (valid drop / data change while stalled).
module rv_target_sink #(
    parameter int unsigned WIDTH     = 32,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [7:0]       cfg_period,
    input  logic             clear,
    output logic [31:0]      xfer_count,
    output logic [WIDTH-1:0] checksum,
    output logic [WIDTH-1:0] last_dat,
    output logic             err_drop,
    output logic             err_change
);

    if (LFSR_SEED == 16'h0) begin : g_bad_seed
        $error("rv_target_sink: LFSR_SEED must be non-zero");
    end

    typedef enum logic [1:0] {
        ModeAlways   = 2'd0,
        ModePeriodic = 2'd1,
        ModeRandom   = 2'd2,
        ModeStall    = 2'd3
    } mode_e;

    mode_e            mode;
    logic             ready_q, ready_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [31:0]      count_q, count_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             drop_q, drop_d;
    logic             chg_q, chg_d;
    logic             stall_q;
    logic [WIDTH-1:0] stall_dat_q;
    logic             xfer, drop_det, chg_det;

    assign mode = mode_e'(cfg_mode);

    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        // >= also covers a period lowered below the current count
        cnt_d  = (cnt_q >= cfg_period) ? 8'd0 : cnt_q + 8'd1;

        ready_d = 1'b0;
        unique case (mode)
            ModeAlways:   ready_d = 1'b1;
            ModePeriodic: ready_d = (cnt_q == cfg_period);
            ModeRandom:   ready_d = lfsr_d[0];
            ModeStall:    ready_d = 1'b0;
            default:      ready_d = 1'b0;
        endcase
    end

    always_comb begin
        xfer     = i_valid && ready_q;
        drop_det = stall_q && !i_valid;
        chg_det  = stall_q && i_valid && (i_dat != stall_dat_q);

        count_d = clear ? 32'd0 : count_q;
        sum_d   = clear ? '0 : sum_q;
        last_d  = clear ? '0 : last_q;
        if (xfer) begin
            count_d = count_d + 32'd1;
            sum_d   = {sum_d[WIDTH-2:0], sum_d[WIDTH-1]} ^ i_dat;
            last_d  = i_dat;
        end

        drop_d = (clear ? 1'b0 : drop_q) | drop_det;
        chg_d  = (clear ? 1'b0 : chg_q) | chg_det;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ready_q     <= 1'b0;
            cnt_q       <= 8'd0;
            lfsr_q      <= LFSR_SEED;
            count_q     <= 32'd0;
            sum_q       <= '0;
            last_q      <= '0;
            drop_q      <= 1'b0;
            chg_q       <= 1'b0;
            stall_q     <= 1'b0;
            stall_dat_q <= '0;
        end else begin
            ready_q     <= ready_d;
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            last_q      <= last_d;
            drop_q      <= drop_d;
            chg_q       <= chg_d;
            stall_q     <= i_valid && !ready_q;
            stall_dat_q <= i_dat;
        end
    end

    assign i_ready    = ready_q;
    assign xfer_count = count_q;
    assign checksum   = sum_q;
    assign last_dat   = last_q;
    assign err_drop   = drop_q;
    assign err_change = chg_q;

endmodule

// File: tb/tb_rv_target_sink.sv
// Self-checking bench for rv_target_sink: directed table, hand sequences and a
// randomized run against a cycle-level reference model.
module tb_rv_target_sink;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] i_dat = '0;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [1:0]  cfg_mode = 2'd0;
    logic [7:0]  cfg_period = 8'd0;
    logic        clear = 1'b0;
    logic [31:0] xfer_count;
    logic [31:0] checksum;
    logic [31:0] last_dat;
    logic        err_drop;
    logic        err_change;

    int checks = 0;
    int errors = 0;

    rv_target_sink #(
        .WIDTH    (32),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .i_dat     (i_dat),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .cfg_mode  (cfg_mode),
        .cfg_period(cfg_period),
        .clear     (clear),
        .xfer_count(xfer_count),
        .checksum  (checksum),
        .last_dat  (last_dat),
        .err_drop  (err_drop),
        .err_change(err_change)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic        m_ready, m_stall, m_edrop, m_echg;
    int          m_phase;
    logic [15:0] m_lfsr;
    logic [31:0] m_count, m_sum, m_last, m_sdat;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        int fb;
        fb = (v >> 0 ^ v >> 2 ^ v >> 3 ^ v >> 5) & 1;
        return 16'((v >> 1) | (fb << 15));
    endfunction

    // Apply the rules for one rising edge using the inputs currently driven
    task automatic model_edge();
        logic        r, x, dd, dc;
        logic [15:0] nl;
        if (reset) begin
            m_ready = 0; m_phase = 0; m_lfsr = 16'hACE1;
            m_count = 0; m_sum = 0; m_last = 0;
            m_edrop = 0; m_echg = 0; m_stall = 0; m_sdat = 0;
            return;
        end
        x  = i_valid && m_ready;
        dd = m_stall && !i_valid;
        dc = m_stall && i_valid && (i_dat != m_sdat);
        nl = lfsr_next(m_lfsr);
        case (cfg_mode)
            2'd0:    r = 1;
            2'd1:    r = (m_phase == int'(cfg_period));
            2'd2:    r = nl[0];
            default: r = 0;
        endcase
        m_phase = (m_phase >= int'(cfg_period)) ? 0 : m_phase + 1;
        m_lfsr  = nl;
        if (clear) begin
            m_count = 0; m_sum = 0; m_last = 0; m_edrop = 0; m_echg = 0;
        end
        if (x) begin
            m_count = m_count + 1;
            m_sum   = ((m_sum << 1) | (m_sum >> 31)) ^ i_dat;
            m_last  = i_dat;
        end
        m_edrop = m_edrop | dd;
        m_echg  = m_echg | dc;
        m_stall = i_valid && !m_ready;
        m_sdat  = i_dat;
        m_ready = r;
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model(input string tag);
        check({tag, ".ready"}, 32'(i_ready), 32'(m_ready));
        check({tag, ".count"}, xfer_count, m_count);
        check({tag, ".sum"}, checksum, m_sum);
        check({tag, ".last"}, last_dat, m_last);
        check({tag, ".drop"}, 32'(err_drop), 32'(m_edrop));
        check({tag, ".chg"}, 32'(err_change), 32'(m_echg));
    endtask

    task automatic do_reset(input logic [1:0] mode, input logic [7:0] per);
        reset = 1; i_valid = 0; clear = 0; cfg_mode = mode; cfg_period = per;
        step();
        step();
        reset = 0;
    endtask

    typedef struct {
        logic        valid;
        logic [31:0] dat;
        logic        clr;
        logic        exp_ready;
        logic [31:0] exp_cnt;
        logic [31:0] exp_sum;
        logic [31:0] exp_last;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int sent, cyc;
        logic hs;

        tbl[0] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'd0, 32'h0,  32'h0};
        tbl[1] = '{1'b1, 32'h1,  1'b0, 1'b1, 32'd1, 32'h1,  32'h1};
        tbl[2] = '{1'b1, 32'h2,  1'b0, 1'b1, 32'd2, 32'h0,  32'h2};
        tbl[3] = '{1'b1, 32'h3,  1'b0, 1'b1, 32'd3, 32'h3,  32'h3};
        tbl[4] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'd0, 32'h0,  32'h0};
        tbl[5] = '{1'b1, 32'h55, 1'b1, 1'b1, 32'd1, 32'h55, 32'h55};

        // Reset state and mode-0 back-to-back stream
        do_reset(2'd0, 8'd0);
        check("rst.ready", 32'(i_ready), 32'd0);
        check("rst.count", xfer_count, 32'd0);
        check("rst.sum", checksum, 32'd0);
        check("rst.errs", {30'd0, err_drop, err_change}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            i_valid = tbl[i].valid; i_dat = tbl[i].dat; clear = tbl[i].clr;
            step();
            check($sformatf("tbl%0d.ready", i), 32'(i_ready), 32'(tbl[i].exp_ready));
            check($sformatf("tbl%0d.count", i), xfer_count, tbl[i].exp_cnt);
            check($sformatf("tbl%0d.sum", i), checksum, tbl[i].exp_sum);
            check($sformatf("tbl%0d.last", i), last_dat, tbl[i].exp_last);
        end
        i_valid = 0; clear = 0;

        // Periodic mode, P=3, valid always high
        do_reset(2'd1, 8'd3);
        i_valid = 1; i_dat = 32'h100; cyc = 0;
        while (xfer_count < 8 && cyc < 100) begin
            hs = i_valid && i_ready;
            step();
            cyc++;
            if (hs) i_dat = i_dat + 1;
            cmp_model("per");
        end
        i_valid = 0;
        check("per.cycles_ok", 32'(cyc >= 29 && cyc <= 35), 32'd1);
        check("per.errs", {30'd0, err_drop, err_change}, 32'd0);

        // Random backpressure, well-behaved initiator sending 100 items
        do_reset(2'd2, 8'd0);
        sent = 0; cyc = 0;
        i_valid = 1; i_dat = $urandom;
        while (sent < 100 && cyc < 2000) begin
            hs = i_valid && i_ready;
            step();
            cyc++;
            if (hs) begin
                sent++;
                i_dat = $urandom;
                if (sent == 100) i_valid = 0;
            end
            cmp_model("rnd");
        end
        check("rnd.count100", xfer_count, 32'd100);
        check("rnd.sum", checksum, m_sum);
        check("rnd.errs", {30'd0, err_drop, err_change}, 32'd0);

        // Stall mode: valid dropped while stalled
        do_reset(2'd3, 8'd0);
        i_valid = 1; i_dat = 32'hDEAD;
        step(); step();
        i_valid = 0;
        step(); step();
        check("drop.err_drop", 32'(err_drop), 32'd1);
        check("drop.err_change", 32'(err_change), 32'd0);
        check("drop.count", xfer_count, 32'd0);

        // Stall mode: data changed while stalled, then clear and accept
        do_reset(2'd3, 8'd0);
        i_valid = 1; i_dat = 32'h5;
        step();
        i_dat = 32'h6;
        step();
        check("chg.err_change", 32'(err_change), 32'd1);
        check("chg.err_drop", 32'(err_drop), 32'd0);
        clear = 1;
        step();
        clear = 0;
        check("chg.clr_drop", 32'(err_drop), 32'd0);
        check("chg.clr_change", 32'(err_change), 32'd0);
        cfg_mode = 2'd0;
        step();
        step();
        i_valid = 0;
        step();
        check("chg.count", xfer_count, 32'd1);
        check("chg.last", last_dat, 32'h6);
        check("chg.errs", {30'd0, err_drop, err_change}, 32'd0);

        // Clear and transfer in the same cycle
        do_reset(2'd0, 8'd0);
        i_valid = 1;
        for (int i = 0; i < 4; i++) begin
            i_dat = 32'hFFFFFFFF;
            step();
        end
        i_dat = 32'hCAFE_0001; clear = 1;
        step();
        i_valid = 0; clear = 0;
        check("clrx.count", xfer_count, 32'd1);
        check("clrx.sum", checksum, 32'hCAFE_0001);
        check("clrx.last", last_dat, 32'hCAFE_0001);

        // Reset mid-stall: no error may survive
        do_reset(2'd3, 8'd0);
        i_valid = 1; i_dat = 32'h77;
        step();
        reset = 1;
        step();
        check("rststall.ready", 32'(i_ready), 32'd0);
        reset = 0; i_valid = 0;
        step();
        check("rststall.errs", {30'd0, err_drop, err_change}, 32'd0);

        // Unconstrained random traffic against the model
        do_reset(2'd0, 8'd0);
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            clear = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) begin
                cfg_mode   = 2'($urandom_range(0, 3));
                cfg_period = 8'($urandom_range(0, 5));
            end
            i_valid = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 3) == 0) i_dat = 32'($urandom_range(0, 3));
            step();
            cmp_model("chaos");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
